crp16_alu_shifter_pipe: RTL and testbench



---
 rtl/crp16_alu_shifter_pipe.sv | 175 +++++++++++++++++
 tb/tb_crp16_alu_shifter_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crp16_alu_shifter_pipe.sv
// crp16_alu_shifter_pipe: elastic log2(WIDTH)-stage shifter/rotator for
// the CRP16 ALU. Ports: clock, reset, flush; in_valid/in_ready/in_x/
// in_shamt/in_op upstream; out_valid/out_ready/out_data/out_carry/out_zero
// downstream. Optional ROR via `define CRP16_SHIFTER_ROTATE_EN.
module crp16_alu_shifter_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero
);

  localparam int LAST = SHAMT_W - 1;

  logic in_lft;
  logic in_fil;
`ifdef CRP16_SHIFTER_ROTATE_EN
  logic in_rot;
  assign in_lft = (in_op == 2'b10);
  assign in_rot = (in_op == 2'b11);
`else
  assign in_lft = in_op[1];
`endif
  // ASR sign captured once at acceptance and carried down
  assign in_fil = (in_op == 2'b01) & in_x[WIDTH-1];

  logic [SHAMT_W:0] rdy;
  assign rdy[SHAMT_W] = out_ready;
  assign in_ready = rdy[0];

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stg
    localparam int S = 1 << k;

    logic             v_i;
    logic             l_i;
    logic             f_i;
    logic             c_i;
    logic [WIDTH-1:0] d_i;
    logic [SHAMT_W-1:k] s_i;
`ifdef CRP16_SHIFTER_ROTATE_EN
    logic             r_i;
`endif

    if (k == 0) begin : g_head
      assign v_i = in_valid;
      assign l_i = in_lft;
      assign f_i = in_fil;
      assign c_i = 1'b0;
      assign d_i = in_x;
      assign s_i = in_shamt;
`ifdef CRP16_SHIFTER_ROTATE_EN
      assign r_i = in_rot;
`endif
    end else begin : g_body
      assign v_i = g_stg[k-1].vq;
      assign l_i = g_stg[k-1].g_ctl.lq;
      assign f_i = g_stg[k-1].g_ctl.fq;
      assign c_i = g_stg[k-1].cq;
      assign d_i = g_stg[k-1].dq;
      assign s_i = g_stg[k-1].g_ctl.sq;
`ifdef CRP16_SHIFTER_ROTATE_EN
      assign r_i = g_stg[k-1].g_ctl.rq;
`endif
    end

    logic [WIDTH-1:0] rsh;
    logic [WIDTH-1:0] lsh;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i + S < WIDTH) begin : g_rin
        assign rsh[i] = d_i[i+S];
      end else begin : g_rtop
`ifdef CRP16_SHIFTER_ROTATE_EN
        // rotate wraps the low bits round to the top
        assign rsh[i] = r_i ? d_i[i+S-WIDTH] : f_i;
`else
        assign rsh[i] = f_i;
`endif
      end
      if (i >= S) begin : g_lin
        assign lsh[i] = d_i[i-S];
      end else begin : g_lbot
        assign lsh[i] = 1'b0;
      end
    end

    logic [WIDTH-1:0] d_o;
    logic             c_o;

    // carry tracks the last bit pushed out by a shifting stage
    always_comb begin
      d_o = d_i;
      c_o = c_i;
      if (s_i[k]) begin
        if (l_i) begin
          d_o = lsh;
          c_o = d_i[WIDTH-S];
        end else begin
          d_o = rsh;
          c_o = d_i[S-1];
        end
      end
    end

    logic             vq;
    logic             cq;
    logic [WIDTH-1:0] dq;

    assign rdy[k] = !vq | rdy[k+1];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vq <= 1'b0;
        cq <= 1'b0;
        dq <= '0;
      end else if (flush) begin
        vq <= 1'b0;
      end else if (rdy[k]) begin
        vq <= v_i;
        if (v_i) begin
          dq <= d_o;
          cq <= c_o;
        end
      end
    end

    if (k < LAST) begin : g_ctl
      logic               lq;
      logic               fq;
      logic [SHAMT_W-1:k+1] sq;
`ifdef CRP16_SHIFTER_ROTATE_EN
      logic               rq;
`endif

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          lq <= 1'b0;
          fq <= 1'b0;
          sq <= '0;
        end else if (!flush && rdy[k] && v_i) begin
          lq <= l_i;
          fq <= f_i;
          sq <= s_i[SHAMT_W-1:k+1];
        end
      end

`ifdef CRP16_SHIFTER_ROTATE_EN
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rq <= 1'b0;
        end else if (!flush && rdy[k] && v_i) begin
          rq <= r_i;
        end
      end
`endif
    end
  end

  assign out_valid = g_stg[LAST].vq;
  assign out_data  = g_stg[LAST].dq;
  assign out_carry = g_stg[LAST].cq;
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_crp16_alu_shifter_pipe.sv
// tb_crp16_alu_shifter_pipe: directed-vector bench for the pipelined
// shifter, WIDTH=16; covers shifts, stall, flush and async reset.
module tb_crp16_alu_shifter_pipe;

  localparam int W  = 16;
  localparam int SW = 4;

  localparam logic [1:0] LSR = 2'b00;
  localparam logic [1:0] ASR = 2'b01;
  localparam logic [1:0] LSL = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_x;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;

  int n_cmp = 0;
  int n_bad = 0;

  crp16_alu_shifter_pipe #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // entered and left at posedge+1
  task automatic run_op(input string tag,
                        input logic [W-1:0] x,
                        input logic [SW-1:0] sh,
                        input logic [1:0] op,
                        input logic [W-1:0] ed,
                        input logic ec);
    int cyc;
    in_valid  = 1'b1;
    in_x      = x;
    in_shamt  = sh;
    in_op     = op;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd4);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_carry"}, 32'(out_carry), 32'(ec));
    chk({tag, "_zero"}, 32'(out_zero), 32'(ed == '0));
    @(posedge clock);
    #1;
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
  endtask

  logic [W-1:0]  bp_x   [6];
  logic [SW-1:0] bp_sh  [6];
  logic [1:0]    bp_op  [6];
  logic [W-1:0]  bp_exp [6];

  logic [W-1:0] ror_d1;
  logic [W-1:0] ror_d2;

  initial begin
    int idx;
    int got;
    int cyc;
    logic acc;
    logic seen;

    bp_x[0] = 16'h1234; bp_sh[0] = 4'd4;  bp_op[0] = LSR; bp_exp[0] = 16'h0123;
    bp_x[1] = 16'h1234; bp_sh[1] = 4'd4;  bp_op[1] = LSL; bp_exp[1] = 16'h2340;
    bp_x[2] = 16'hF000; bp_sh[2] = 4'd8;  bp_op[2] = ASR; bp_exp[2] = 16'hFFF0;
    bp_x[3] = 16'h00FF; bp_sh[3] = 4'd2;  bp_op[3] = LSR; bp_exp[3] = 16'h003F;
    bp_x[4] = 16'h000F; bp_sh[4] = 4'd12; bp_op[4] = LSL; bp_exp[4] = 16'hF000;
    bp_x[5] = 16'h8421; bp_sh[5] = 4'd1;  bp_op[5] = LSR; bp_exp[5] = 16'h4210;

`ifdef CRP16_SHIFTER_ROTATE_EN
    ror_d1 = 16'h3001;
    ror_d2 = 16'hC000;
`else
    ror_d1 = 16'h0130;
    ror_d2 = 16'h0002;
`endif

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_shamt  = '0;
    in_op     = 2'b00;
    out_ready = 1'b1;

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_carry", 32'(out_carry), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run_op("lsr_f0f1_4", 16'hF0F1, 4'd4, LSR, 16'h0F0F, 1'b0);
    run_op("asr_8001_15", 16'h8001, 4'd15, ASR, 16'hFFFF, 1'b0);
    run_op("asr_4003_1", 16'h4003, 4'd1, ASR, 16'h2001, 1'b1);
    run_op("lsl_8001_1", 16'h8001, 4'd1, LSL, 16'h0002, 1'b1);
    run_op("lsl_0001_0", 16'h0001, 4'd0, LSL, 16'h0001, 1'b0);
    run_op("ror_0013_4", 16'h0013, 4'd4, ROR, ror_d1, 1'b0);
    run_op("ror_8001_1", 16'h8001, 4'd1, ROR, ror_d2, 1'b1);
    run_op("lsr_0001_1", 16'h0001, 4'd1, LSR, 16'h0000, 1'b1);
    run_op("lsr_8000_15", 16'h8000, 4'd15, LSR, 16'h0001, 1'b0);
    run_op("asr_8000_0", 16'h8000, 4'd0, ASR, 16'h8000, 1'b0);
    run_op("lsl_0003_15", 16'h0003, 4'd15, LSL, 16'h8000, 1'b1);

    // back-pressure: fill with out_ready low
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        in_x     = bp_x[idx];
        in_shamt = bp_sh[idx];
        in_op    = bp_op[idx];
      end
      #1;
      acc = in_valid & in_ready;
      @(posedge clock);
      #1;
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_full_rdy", 32'(in_ready), 32'd0);
    chk("bp_full_vld", 32'(out_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      chk("bp_hold_data", 32'(out_data), 32'(bp_exp[0]));
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    end

    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        in_x     = bp_x[idx];
        in_shamt = bp_sh[idx];
        in_op    = bp_op[idx];
      end
      #1;
      if (c == 0) chk("bp_nobubble", 32'(in_ready), 32'd1);
      acc = in_valid & in_ready;
      if (out_valid) begin
        chk("bp_order", 32'(out_data), 32'(bp_exp[got]));
        got++;
      end
      cyc++;
      @(posedge clock);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(got), 32'd6);
    chk("bp_cycles", 32'(cyc), 32'd6);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen = seen | out_valid;
      @(posedge clock);
      #1;
    end
    chk("bp_nodup", 32'(seen), 32'd0);

    // flush with two in flight and an input offered alongside
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_x     = 16'h00F0 + 16'(c);
      in_shamt = 4'd1;
      in_op    = LSL;
      flush    = (c == 2);
      @(posedge clock);
      #1;
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seen = seen | out_valid;
      @(posedge clock);
      #1;
    end
    chk("flush_none", 32'(seen), 32'd0);
    chk("flush_rdy", 32'(in_ready), 32'd1);

    // async reset while a result is held at the output
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 16'hF0F1;
    in_shamt  = 4'd0;
    in_op     = LSR;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
    end
    chk("mid_pre_vld", 32'(out_valid), 32'd1);
    chk("mid_pre_data", 32'(out_data), 32'hF0F1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_zero", 32'(out_zero), 32'd1);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
